tx_serializer: RTL and testbench

Parallel-to-serial transmit stage for the photonic link. It accepts one WIDTH-bit word from the upstream pipeline register through a valid/ready handshake and shifts it onto a single-bit optical drive line as a framed bit stream: start bit, data LSB first, then optional parity. It sits between the core's transmit-side output register and the modulator driver, one bit per clock.

---
 rtl/tx_pkg.sv | 15 +
 rtl/tx_serializer_shift_reg.sv | 43 ++++
 rtl/tx_serializer.sv | 144 ++++++++++++++
 tb/tb_tx_serializer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/tx_pkg.sv
// Shared types and line levels for the photonic-link transmit serializer.
// The optional parity feature is selected by TX_SERIALIZER_PARITY_EN.
package tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_START  = 2'd1,
        ST_DATA   = 2'd2,
        ST_PARITY = 2'd3
    } tx_state_t;

    localparam logic START_LEVEL = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b0;

endpackage

// File: rtl/tx_serializer_shift_reg.sv
// Right-shifting word register feeding the serial line; load wins over shift.
// Built the same way whether or not TX_SERIALIZER_PARITY_EN is defined.
module shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             lsb
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Each bit either reloads, takes its upper neighbour, or holds.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_bit
            assign q_d[gi] = load  ? d[gi]       :
                             shift ? q_q[gi + 1] :
                                     q_q[gi];
        end
    endgenerate

    assign q_d[WIDTH-1] = load  ? d[WIDTH-1] :
                          shift ? 1'b0       :
                                  q_q[WIDTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q   = q_q;
    assign lsb = q_q[0];

endmodule

// File: rtl/tx_serializer.sv
// Framed parallel-to-serial transmitter: start bit, data LSB first, optional
// even parity when TX_SERIALIZER_PARITY_EN is defined. All outputs registered.
module tx_serializer
    import tx_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             tx_out,
    output logic             tx_active,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    tx_state_t        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             tx_q, tx_d;
    logic             active_q, active_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;

    logic             sr_load;
    logic             sr_shift;
    logic [WIDTH-1:0] sr_q;
    logic             sr_lsb;

`ifdef TX_SERIALIZER_PARITY_EN
    logic             parity_q, parity_d;
`else
    logic             sr_q_unused;
    assign sr_q_unused = ^sr_q;
`endif

    shift_reg #(
        .WIDTH (WIDTH)
    ) u_shift_reg (
        .clk   (clk),
        .rst   (rst),
        .load  (sr_load),
        .shift (sr_shift),
        .d     (data_in),
        .q     (sr_q),
        .lsb   (sr_lsb)
    );

    // Outputs are computed for the cycle being entered, so the register sees
    // the bit one shift ahead of what is currently on the line.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sr_load  = 1'b0;
        sr_shift = 1'b0;
        tx_d     = IDLE_LEVEL;
        done_d   = 1'b0;
`ifdef TX_SERIALIZER_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (valid_in && ready_q) begin
                    sr_load = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_START;
                    tx_d    = START_LEVEL;
                end
            end
            ST_START: begin
                sr_shift = 1'b1;
                state_d  = ST_DATA;
                tx_d     = sr_lsb;
`ifdef TX_SERIALIZER_PARITY_EN
                parity_d = ^sr_q;
`endif
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
`ifdef TX_SERIALIZER_PARITY_EN
                    state_d = ST_PARITY;
                    tx_d    = parity_q;
`else
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
`endif
                end else begin
                    sr_shift = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                    tx_d     = sr_lsb;
                end
            end
`ifdef TX_SERIALIZER_PARITY_EN
            ST_PARITY: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        active_d = (state_d != ST_IDLE);
        ready_d  = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            tx_q     <= IDLE_LEVEL;
            active_q <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tx_q     <= tx_d;
            active_q <= active_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
        end
    end

`ifdef TX_SERIALIZER_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

    assign ready_out = ready_q;
    assign tx_out    = tx_q;
    assign tx_active = active_q;
    assign done      = done_q;

endmodule

// File: tb/tb_tx_serializer.sv
// Directed plus random frames for tx_serializer, checked cycle by cycle against
// a frame list built from the word. Honours TX_SERIALIZER_PARITY_EN.
module tb_tx_serializer;

    localparam int W = 8;
`ifdef TX_SERIALIZER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic         clk;
    logic         rst;
    logic [W-1:0] data_in;
    logic         valid_in;
    logic         ready_out;
    logic         tx_out;
    logic         tx_active;
    logic         done;

    int n_checks = 0;
    int n_fail   = 0;

    tx_serializer #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .tx_out    (tx_out),
        .tx_active (tx_active),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag, input logic exp_done);
        check({tag, " ready_out"}, ready_out, 1'b1);
        check({tag, " tx_out"},    tx_out,    1'b0);
        check({tag, " tx_active"}, tx_active, 1'b0);
        check({tag, " done"},      done,      exp_done);
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (ready_out !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("wait_ready", ready_out, 1'b1);
    endtask

    // Caller has already driven valid_in/data_in for the accept edge. Checks
    // every cycle from the start bit to the done cycle, ending on its negedge.
    task automatic run_frame(input logic [W-1:0] word, input logic nv,
                             input logic [W-1:0] nw, input int pulse_at,
                             input int abort_at);
        logic exp_q[$];
        logic exp_tx;
        int   fl;
        bit   aborted;
        exp_q = {};
        exp_q.push_back(1'b1);
        for (int i = 0; i < W; i++) exp_q.push_back(word[i]);
        if (PAR != 0) exp_q.push_back(^word);
        fl = exp_q.size();
        aborted = 1'b0;

        @(posedge clk);
        @(negedge clk);
        valid_in = nv;
        data_in  = nv ? nw : W'($urandom);
        for (int j = 0; j <= fl; j++) begin
            exp_tx = (j < fl) ? exp_q[j] : 1'b0;
            check($sformatf("tx_out w=%h c=%0d", word, j),    tx_out,    exp_tx);
            check($sformatf("tx_active w=%h c=%0d", word, j), tx_active, j < fl);
            check($sformatf("ready_out w=%h c=%0d", word, j), ready_out, j == fl);
            check($sformatf("done w=%h c=%0d", word, j),      done,      j == fl);
            if (j == abort_at) begin
                rst = 1'b1;
                aborted = 1'b1;
                break;
            end
            if (j == pulse_at) begin
                valid_in = 1'b1;
                data_in  = 8'h3C;
            end else if (j == pulse_at + 1) begin
                valid_in = nv;
                data_in  = nw;
            end
            if (j < fl) @(negedge clk);
        end
        $display("frame word=%h bits=%0d next_valid=%0d %s", word, fl, nv,
                 aborted ? "aborted by reset" : "complete");
    endtask

    initial begin
        logic [W-1:0] cur;
        logic [W-1:0] nxt;

        rst      = 1'b1;
        valid_in = 1'b0;
        data_in  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset", 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_idle($sformatf("idle%0d", i), 1'b0);
        end

        wait_ready();
        valid_in = 1'b1;
        data_in  = 8'hA5;
        run_frame(8'hA5, 1'b0, '0, -1, -1);

        // Back-to-back: 0xFF is presented while 0x01 is still being sent.
        wait_ready();
        valid_in = 1'b1;
        data_in  = 8'h01;
        run_frame(8'h01, 1'b1, 8'hFF, -1, -1);
        run_frame(8'hFF, 1'b0, '0, -1, -1);
        @(negedge clk);
        check_idle("after_ff", 1'b0);

        // A one-cycle 0x3C offer mid-frame must be ignored.
        wait_ready();
        valid_in = 1'b1;
        data_in  = 8'h5A;
        run_frame(8'h5A, 1'b0, '0, 3, -1);
        @(negedge clk);
        check_idle("after_3c", 1'b0);

        // Reset while data bit 4 of 0xF0 is on the line.
        wait_ready();
        valid_in = 1'b1;
        data_in  = 8'hF0;
        run_frame(8'hF0, 1'b0, '0, -1, 5);
        @(negedge clk);
        check_idle("abort", 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check_idle("abort_nodone", 1'b0);

        wait_ready();
        valid_in = 1'b1;
        data_in  = 8'h55;
        run_frame(8'h55, 1'b0, '0, -1, -1);

        wait_ready();
        valid_in = 1'b1;
        data_in  = 8'h07;
        run_frame(8'h07, 1'b0, '0, -1, -1);

        // Random chain of back-to-back frames.
        wait_ready();
        cur      = W'($urandom);
        valid_in = 1'b1;
        data_in  = cur;
        for (int n = 0; n < 8; n++) begin
            nxt = W'($urandom);
            run_frame(cur, n != 7, nxt, (n % 3 == 0) ? 2 : -1, -1);
            cur = nxt;
        end
        @(negedge clk);
        check_idle("final", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
